// File: rtl/tpm_pkg.sv
// -----------------------------------------------------------------------------
// tpm_pkg
// Shared definitions for the toggle period meter:
//   - ST_* : 2-bit state encoding of the measurement FSM
//   - tpm_state_e : enum built on that encoding
//   - CW_DEF / PW_DEF : default widths of the toggle counter and period timer
// -----------------------------------------------------------------------------
package tpm_pkg;

  localparam int CW_DEF = 8;
  localparam int PW_DEF = 8;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FIRST = 2'd1;
  localparam logic [1:0] ST_MEASURE    = 2'd2;
  localparam logic [1:0] ST_STUCK      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE       = ST_IDLE,
    S_WAIT_FIRST = ST_WAIT_FIRST,
    S_MEASURE    = ST_MEASURE,
    S_STUCK      = ST_STUCK
  } tpm_state_e;

endpackage

// File: rtl/tpm_edge_detect.sv
// -----------------------------------------------------------------------------
// tpm_edge_detect
// Registers the previous value of q and derives rising-edge and toggle strobes
// combinationally against the current sample.
// Ports:
//   clk     : system clock, rising-edge active
//   reset   : asynchronous active-high reset (q_prev -> 0)
//   q_i     : q from the T flip-flop, already in the clk domain
//   rise_o  : q_i & ~q_prev
//   tog_o   : q_i ^ q_prev
// -----------------------------------------------------------------------------
module tpm_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic q_i,
  output logic rise_o,
  output logic tog_o
);

  logic q_prev_q;

  // q_prev follows q every cycle regardless of FSM state, so enabling the
  // meter never sees a stale previous value and cannot create a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_prev_q <= 1'b0;
    end else begin
      q_prev_q <= q_i;
    end
  end

  assign rise_o = q_i & ~q_prev_q;
  assign tog_o  = q_i ^ q_prev_q;

endmodule

// File: rtl/toggle_period_meter.sv
// -----------------------------------------------------------------------------
// toggle_period_meter
// Watches the T flip-flop output, counts its toggles, measures the number of
// clk cycles between consecutive rising edges and flags a stuck output when no
// rising edge arrives within TIMEOUT cycles.
// Ports:
//   clk          : system clock, rising-edge active
//   reset        : asynchronous active-high reset
//   q_in         : q from the T flip-flop (same clock domain, no synchronizer)
//   enable       : measurement enable (level)
//   clear        : synchronous clear of counters and flags (one-cycle pulse)
//   edge_count   : toggles seen while active, wraps modulo 2^CW
//   overflow     : sticky, set when edge_count wraps
//   period       : last measured rising-to-rising interval in clk cycles
//   period_valid : one-cycle pulse when period updates
//   stuck        : no rising edge within TIMEOUT cycles
// All outputs are registered. TIMEOUT must satisfy 2 <= TIMEOUT < 2^PW-1.
// -----------------------------------------------------------------------------
module toggle_period_meter
  import tpm_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int PW      = PW_DEF,
  parameter int TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          q_in,
  input  logic          enable,
  input  logic          clear,
  output logic [CW-1:0] edge_count,
  output logic          overflow,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          stuck
);

  // Timer value on which the timeout fires; the timer never goes past it, so
  // timer+1 always fits in PW bits and period needs no saturation.
  localparam logic [PW-1:0] TIMER_LAST = PW'(TIMEOUT - 1);

  logic rise;
  logic tog;

  tpm_state_e    state_q,  state_d;
  logic [PW-1:0] timer_q,  timer_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic [PW-1:0] period_q, period_d;
  logic          pv_q,     pv_d;
  logic          stuck_q,  stuck_d;

  tpm_edge_detect u_edge_detect (
    .clk    (clk),
    .reset  (reset),
    .q_i    (q_in),
    .rise_o (rise),
    .tog_o  (tog)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      period_q <= '0;
      pv_q     <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      stuck_q  <= stuck_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    period_d = period_q;
    pv_d     = 1'b0;
    stuck_d  = stuck_q;

    if (clear) begin
      // Clear outranks everything: edges in this cycle are neither counted
      // nor measured; the timing reference restarts from here.
      count_d  = '0;
      ovf_d    = 1'b0;
      period_d = '0;
      stuck_d  = 1'b0;
      timer_d  = '0;
      state_d  = enable ? S_WAIT_FIRST : S_IDLE;
    end else if (!enable) begin
      // Dropping enable abandons any measurement; a rise here is ignored.
      state_d = S_IDLE;
      stuck_d = 1'b0;
      timer_d = '0;
    end else begin
      if ((state_q != S_IDLE) && tog) begin
        count_d = count_q + 1'b1;
        if (&count_q) begin
          ovf_d = 1'b1;
        end
      end

      unique case (state_q)
        S_IDLE: begin
          timer_d = '0;
          state_d = S_WAIT_FIRST;
        end
        S_WAIT_FIRST: begin
          // The first rise only establishes the reference point.
          if (rise) begin
            state_d = S_MEASURE;
            timer_d = '0;
          end else if (timer_q == TIMER_LAST) begin
            state_d = S_STUCK;
            stuck_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_MEASURE: begin
          // Timer was zeroed on the previous rise, hence the +1.
          if (rise) begin
            period_d = timer_q + 1'b1;
            pv_d     = 1'b1;
            timer_d  = '0;
          end else if (timer_q == TIMER_LAST) begin
            state_d = S_STUCK;
            stuck_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_STUCK: begin
          // The interval that timed out is not reported; the rise just
          // restarts measurement.
          if (rise) begin
            state_d = S_MEASURE;
            timer_d = '0;
            stuck_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign edge_count   = count_q;
  assign overflow     = ovf_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign stuck        = stuck_q;

endmodule

// File: tb/tb_toggle_period_meter.sv
// -----------------------------------------------------------------------------
// tb_toggle_period_meter
// Directed scenarios followed by randomized stimulus. A cycle-stamp model
// (times of the last reference event instead of a running timer) predicts the
// outputs and every clocked cycle is compared against it; literal checks pin
// key values of the model.
// -----------------------------------------------------------------------------
module tb_toggle_period_meter;

  localparam int CW      = 4;
  localparam int PW      = 8;
  localparam int TIMEOUT = 200;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          q_in   = 1'b0;
  logic          enable = 1'b0;
  logic          clear  = 1'b0;
  logic [CW-1:0] edge_count;
  logic          overflow;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stuck;

  int tests = 0;
  int fails = 0;

  toggle_period_meter #(
    .CW      (CW),
    .PW      (PW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .q_in         (q_in),
    .enable       (enable),
    .clear        (clear),
    .edge_count   (edge_count),
    .overflow     (overflow),
    .period       (period),
    .period_valid (period_valid),
    .stuck        (stuck)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_OFF, M_FIRST, M_RUN, M_STUCK} mmode_e;

  mmode_e m_mode = M_OFF;
  int     m_cnt  = 0;
  bit     m_ovf  = 1'b0;
  int     m_per  = 0;
  bit     m_pv   = 1'b0;
  bit     m_stk  = 1'b0;
  bit     m_qp   = 1'b0;
  int     m_n    = 0;   // clock edge number
  int     m_ref  = 0;   // edge at which the current interval started

  task automatic model_reset();
    m_mode = M_OFF;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_per  = 0;
    m_pv   = 1'b0;
    m_stk  = 1'b0;
    m_qp   = 1'b0;
  endtask

  task automatic model_step();
    bit r;
    bit t;
    if (reset) begin
      model_reset();
      return;
    end
    r    = q_in && !m_qp;
    t    = (q_in != m_qp);
    m_pv = 1'b0;
    if (clear) begin
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_per  = 0;
      m_stk  = 1'b0;
      m_ref  = m_n;
      m_mode = enable ? M_FIRST : M_OFF;
    end else if (!enable) begin
      m_mode = M_OFF;
      m_stk  = 1'b0;
    end else begin
      if (m_mode != M_OFF && t) begin
        m_cnt++;
        if (m_cnt == (1 << CW)) begin
          m_cnt = 0;
          m_ovf = 1'b1;
        end
      end
      case (m_mode)
        M_OFF: begin
          m_mode = M_FIRST;
          m_ref  = m_n;
        end
        M_FIRST, M_RUN: begin
          if (r) begin
            if (m_mode == M_RUN) begin
              m_per = m_n - m_ref;
              m_pv  = 1'b1;
            end
            m_mode = M_RUN;
            m_ref  = m_n;
          end else if (m_n - m_ref == TIMEOUT) begin
            m_mode = M_STUCK;
            m_stk  = 1'b1;
          end
        end
        M_STUCK: begin
          if (r) begin
            m_mode = M_RUN;
            m_ref  = m_n;
            m_stk  = 1'b0;
          end
        end
        default: ;
      endcase
    end
    m_qp = q_in;
    m_n++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    if (!reset) begin
      check("edge_count",   int'(edge_count),   m_cnt);
      check("overflow",     int'(overflow),     int'(m_ovf));
      check("period",       int'(period),       m_per);
      check("period_valid", int'(period_valid), int'(m_pv));
      check("stuck",        int'(stuck),        int'(m_stk));
    end
  endtask

  // Drive inputs at the falling edge, let the DUT and model take the rising
  // edge, then compare at the next falling edge.
  task automatic tick(input logic q, input logic en, input logic clr);
    q_in   = q;
    enable = en;
    clear  = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
    $display("[TB] t=%0t q=%0b en=%0b clr=%0b -> cnt=%0d ovf=%0b per=%0d pv=%0b stuck=%0b",
             $time, q, en, clr, edge_count, overflow, period, period_valid, stuck);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_edge_count"},   int'(edge_count),   0);
    check({tag, "_overflow"},     int'(overflow),     0);
    check({tag, "_period"},       int'(period),       0);
    check({tag, "_period_valid"}, int'(period_valid), 0);
    check({tag, "_stuck"},        int'(stuck),        0);
  endtask

  initial begin
    int pv_cnt;

    // Reset for 3 cycles
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    check_all_zero("reset");
    #2 reset = 1'b0;

    // Disabled: toggling is ignored
    for (int i = 0; i < 8; i++) tick(~q_in, 1'b0, 1'b0);
    check_all_zero("disabled");

    // Toggle every clock: period 2
    for (int i = 0; i < 20; i++) tick(~q_in, 1'b1, 1'b0);
    check("toggle_period", int'(period), 2);

    // Rises at cycles 10, 15, 22 after a clear
    tick(1'b0, 1'b1, 1'b1);
    pv_cnt = 0;
    for (int i = 1; i <= 25; i++) begin
      tick((i == 10 || i == 11 || i == 15 || i == 16 || i == 22 || i == 23), 1'b1, 1'b0);
      if (period_valid) pv_cnt++;
      if (i == 15) check("period_5", int'(period), 5);
    end
    check("period_7", int'(period), 7);
    check("pv_pulses", pv_cnt, 2);

    // Hold q low: stuck after the timer reaches TIMEOUT-1
    for (int j = 26; j <= 230; j++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (j == 221) check("stuck_early", int'(stuck), 0);
      if (j == 222) check("stuck_on", int'(stuck), 1);
    end
    tick(1'b1, 1'b1, 1'b0);
    check("stuck_release", int'(stuck), 0);
    check("stuck_no_pv", int'(period_valid), 0);
    check("stuck_period_kept", int'(period), 7);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("period_3", int'(period), 3);
    check("period_3_pv", int'(period_valid), 1);

    // Counter wrap at 2^CW toggles, then clear coinciding with a toggle
    tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick(~q_in, 1'b1, 1'b0);
      if (i == 14) begin
        check("cnt_15", int'(edge_count), 15);
        check("ovf_before_wrap", int'(overflow), 0);
      end
    end
    check("wrap_count", int'(edge_count), 0);
    check("wrap_ovf", int'(overflow), 1);
    tick(~q_in, 1'b1, 1'b1);
    tick(q_in, 1'b1, 1'b0);
    check("clear_tog_count", int'(edge_count), 0);
    check("clear_tog_ovf", int'(overflow), 0);

    // Randomized traffic with occasional long holds
    for (int b = 0; b < 60; b++) begin
      int   len;
      int   sel;
      logic nq;
      logic ne;
      logic nc;
      sel = int'($urandom_range(0, 9));
      len = (sel == 0) ? int'($urandom_range(190, 215)) : int'($urandom_range(5, 60));
      for (int k = 0; k < len; k++) begin
        if (sel == 0) begin
          nq = q_in;
          ne = 1'b1;
          nc = 1'b0;
        end else begin
          nq = ($urandom_range(0, 2) == 0) ? ~q_in : q_in;
          ne = ($urandom_range(0, 29) != 0);
          nc = ($urandom_range(0, 49) == 0);
        end
        tick(nq, ne, nc);
      end
    end

    // Asynchronous reset mid-MEASURE
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all_zero("async_reset");
    tick(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("post_reset_first_rise_pv", int'(period_valid), 0);
    tick(1'b0, 1'b1, 1'b0);
    check("post_reset_period", int'(period), 0);
    tick(1'b1, 1'b1, 1'b0);
    check("post_reset_period_2", int'(period), 2);
    check("post_reset_pv", int'(period_valid), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/toggle_period_meter.md
Name: toggle_period_meter

Overview:
Downstream consumer of the T flip-flop output q. It tracks the toggle stream, counts toggles, measures the clock-cycle period between consecutive rising edges, and flags a stuck output when no rising edge arrives within a timeout. q_in is produced in the same clk domain, so the block has no synchronizer.

Parameters:
CW, 8, width of toggle counter edge_count
PW, 8, width of period timer and period output
TIMEOUT, 200, cycles without a rising edge before stuck asserts; must satisfy 2 <= TIMEOUT < 2^PW-1

Ports:
clk  input  1  single system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
q_in  input  1  T flip-flop output q, synchronous to clk
enable  input  1  measurement enable, level
clear  input  1  synchronous clear of counters and flags, one-cycle pulse
edge_count  output  CW  toggles (rise or fall) seen while enabled, wraps
overflow  output  1  sticky; set when edge_count wraps from all-ones to 0
period  output  PW  last measured rising-to-rising interval in clk cycles
period_valid  output  1  one-cycle pulse when period updates
stuck  output  1  level; no rising edge within TIMEOUT cycles

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: q_prev=0, timer=0, state=IDLE, edge_count=0, overflow=0, period=0, period_valid=0, stuck=0. Reset mid-measurement discards everything.
- Edge detection: rise = q_in & ~q_prev; tog = q_in ^ q_prev. q_prev <= q_in every cycle in all states, so enabling the block never produces a false edge.
- All outputs are registered. An edge sampled at clk edge k is reflected in the outputs during cycle k+1.
- States (2-bit): IDLE=0, WAIT_FIRST=1, MEASURE=2, STUCK=3.
- IDLE:
  - timer=0; counters and period hold.
  - enable=1 -> WAIT_FIRST.
- WAIT_FIRST:
  - timer increments each cycle.
  - rise -> MEASURE, timer<=0, no period_valid.
  - timer==TIMEOUT-1 with no rise -> STUCK.
- MEASURE:
  - timer increments.
  - rise -> period<=timer+1, period_valid=1 for one cycle, timer<=0. Example: rises sampled at edges 0 and 4 give period=4.
  - timer==TIMEOUT-1 with no rise -> STUCK.
- STUCK:
  - stuck=1; timer holds.
  - rise -> MEASURE, timer<=0, stuck<=0, no period_valid (that interval is invalid); period keeps its old value.
- Leaving enable:
  - enable=0 in any state -> IDLE next cycle: stuck<=0, timer<=0, period_valid=0.
  - A rise in that same cycle is ignored.
- edge_count:
  - Increments on tog in any state except IDLE.
  - Wraps modulo 2^CW; on wrap, overflow<=1, sticky until clear or reset.
- clear:
  - Resets edge_count, overflow, period, stuck and timer.
  - Next state is WAIT_FIRST if enable, else IDLE.
  - Clear has priority: a rise or tog in the clear cycle is not counted and produces no period_valid, but q_prev still updates.
- Simultaneous rise and timeout in WAIT_FIRST/MEASURE: rise wins, no stuck.
- Width rule: timer never exceeds TIMEOUT-1, so period fits in PW bits with no saturation logic.

Decomposition:
- Shared package tpm_pkg holds:
  - state encoding localparams ST_IDLE, ST_WAIT_FIRST, ST_MEASURE, ST_STUCK;
  - default widths CW_DEF=8 and PW_DEF=8.
- One natural sub-module, tpm_edge_detect:
  - holds the q_prev register (async reset);
  - outputs rise and tog;
  - instantiated once.
- Counter, timer and FSM live in the top module.

Test Plan:
- Reset 1 for 3 cycles, then 0 with enable=0 while q_in toggles -> all outputs 0, state IDLE, edge_count stays 0.
- enable=1, drive q_in from T_FF with t=1 (toggle each clk) -> first rise gives no pulse; afterwards period=2 with a period_valid pulse every 2 cycles; edge_count +1 per cycle.
- q_in rises at cycles 10, 15, 22 after enable -> period=5 then period=7, two period_valid pulses only.
- Hold q_in constant for 200 cycles after a rise -> stuck=1 in the cycle after timer reaches 199; next rise clears stuck with no period_valid; the following rise 3 cycles later gives period=3.
- CW=4, 16 toggles -> edge_count wraps to 0 and overflow=1; clear pulse coinciding with a toggle -> edge_count=0, overflow=0, the toggle not counted.
- Assert reset asynchronously mid-MEASURE (not on a clk edge) -> all outputs 0 immediately; after release with enable=1, the first rise produces no period_valid.
